// File: rtl/alu_seq.sv
// Multi-cycle ALU: logic/arithmetic ops complete in one cycle, shifts run serially one bit per cycle.
// start/busy/done handshake; result and zero are registered and change only with done.
module alu_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpSlt  = 4'b0010;
    localparam logic [3:0] OpSltu = 4'b0011;
    localparam logic [3:0] OpAnd  = 4'b0100;
    localparam logic [3:0] OpOr   = 4'b0101;
    localparam logic [3:0] OpXor  = 4'b0110;
    localparam logic [3:0] OpSll  = 4'b1000;
    localparam logic [3:0] OpSrl  = 4'b1001;
    localparam logic [3:0] OpSra  = 4'b1011;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;

    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shifted;
    logic            is_shift;
    logic [4:0]      shamt;

    assign shamt    = b[4:0];
    assign is_shift = (alu_op == OpSll) || (alu_op == OpSrl) || (alu_op == OpSra);

    // Single-cycle datapath; shift ops here cover only the shift-by-zero case.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OpAdd:  alu_res = a + b;
            OpSub:  alu_res = a - b;
            OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OpSltu: alu_res = {{(XLEN-1){1'b0}}, a < b};
            OpAnd:  alu_res = a & b;
            OpOr:   alu_res = a | b;
            OpXor:  alu_res = a ^ b;
            OpSll, OpSrl, OpSra: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // SRA refills with the MSB, which never changes during a right-arithmetic shift.
    always_comb begin
        shifted = {1'b0, shreg_q[XLEN-1:1]};
        if (op_q == OpSll) begin
            shifted = {shreg_q[XLEN-2:0], 1'b0};
        end else if (op_q == OpSra) begin
            shifted = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        op_d    = alu_op;
                        shreg_d = a;
                        cnt_d   = shamt;
                        state_d = StShift;
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                    end
                end
            end
            StShift: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = shifted;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == StShift);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops against a reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, zero;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    alu_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .alu_op (alu_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        int n;
        n = int'(y[4:0]);
        case (op)
            4'b0000: return x + y;
            4'b0001: return x - y;
            4'b0010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0011: return (x < y) ? 32'd1 : 32'd0;
            4'b0100: return x & y;
            4'b0101: return x | y;
            4'b0110: return x ^ y;
            4'b1000: return x << n;
            4'b1001: return x >> n;
            4'b1011: return 32'($signed(x) >>> n);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y);
        if (op == 4'b1000 || op == 4'b1001 || op == 4'b1011) return int'(y[4:0]);
        return 0;
    endfunction

    // Issues one op and follows it to completion, scrambling inputs (incl. start) while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input bit scramble);
        logic [31:0] exp, prev;
        int lat, k;
        exp  = ref_alu(op, x, y);
        lat  = ref_lat(op, y);
        prev = result;
        @(negedge clk);
        start = 1'b1; alu_op = op; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            check("busy_while_shifting", {31'd0, busy}, 32'd1);
            check("result_held", result, prev);
            if (scramble) begin
                start = 1'($urandom); alu_op = 4'($urandom); a = $urandom; b = $urandom;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("latency", k, lat);
        check("result", result, exp);
        check("zero", {31'd0, zero}, {31'd0, exp == 32'd0});
        check("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // ADD wraps to zero
        run_op(4'b0000, 32'hFFFF_FFFF, 32'h1, 1'b0);

        // SLT then SLTU back-to-back
        @(negedge clk);
        start = 1'b1; alu_op = 4'b0010; a = 32'hFFFF_FFFF; b = 32'h1;
        @(negedge clk);
        alu_op = 4'b0011;
        check("slt_done", {31'd0, done}, 32'd1);
        check("slt_result", result, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("sltu_done", {31'd0, done}, 32'd1);
        check("sltu_result", result, 32'd0);
        check("sltu_zero", {31'd0, zero}, 32'd1);

        // SRA with an ADD start at E2 that must be ignored
        @(negedge clk);
        start = 1'b1; alu_op = 4'b1011; a = 32'h8000_0000; b = 32'h4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("sra_busy", {31'd0, busy}, 32'd1);
            check("sra_no_done", {31'd0, done}, 32'd0);
            check("sra_result_held", result, 32'd0);
            start = (i == 2); alu_op = 4'b0000; a = 32'h1; b = 32'h1;
            @(negedge clk);
        end
        start = 1'b0;
        check("sra_done", {31'd0, done}, 32'd1);
        check("sra_result", result, 32'hF800_0000);
        check("sra_busy_end", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("sra_ignored_start", {31'd0, done}, 32'd0);

        run_op(4'b1001, 32'h0000_0010, 32'hFFFF_FF21, 1'b0);
        run_op(4'b1000, 32'h1234_5678, 32'h0000_0020, 1'b0);
        run_op(4'b0111, 32'h1234_5678, 32'h1, 1'b0);

        // Async reset mid-shift
        @(negedge clk);
        start = 1'b1; alu_op = 4'b1000; a = 32'h1; b = 32'd31;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("post_rst_no_done", {30'd0, busy, done}, 32'd0);
        end
        run_op(4'b0110, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0);

        // Randomized ops, with inputs scrambled while a shift is in flight
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            logic [3:0] rop;
            rop = 4'($urandom);
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            run_op(rop, ra, rb, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle ALU execution unit that consumes the 4-bit `alu_op` code produced by the core's ALU-op decoder and operates on two 32-bit operands. Logic and arithmetic ops complete in a single cycle. Shifts are performed serially, one bit per cycle, to save area in the small core variant. A start/busy/done handshake lets the control FSM stall the datapath until the result is valid.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width; shift amount is `b[4:0]`, so only 32 is supported.

Ports:
- `clk`  input  1  single clock, all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled on a rising edge only while idle.
- `alu_op`  input  4  op code: ADD 0000, SUB 0001, SLT 0010, SLTU 0011, AND 0100, OR 0101, XOR 0110, SLL 1000, SRL 1001, SRA 1011.
- `a`  input  XLEN  operand A (shift source).
- `b`  input  XLEN  operand B (shift amount = `b[4:0]`).
- `busy`  output  1  high while a serial shift is in progress.
- `done`  output  1  one-cycle pulse: `result`/`zero` were just updated.
- `result`  output  XLEN  registered result; holds until next completion.
- `zero`  output  1  registered, equals (`result` == 0).

## Operation
- States: IDLE, SHIFT.
- IDLE, `start`=1 at edge E0: latch `alu_op`, `a`, `b`. Inputs are ignored after E0.
  - Non-shift op, or shift with `b[4:0]`=0: write `result` at E0, set `done`=1, stay in IDLE.
  - Shift with n=`b[4:0]`>0: shift register <= `a`, count <= n, enter SHIFT, `busy`=1.
- SHIFT, each edge: shift register shifted by one position, count decremented.
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, fill with latched `a[31]`.
  - On the edge where count reaches 0: `result` <= shifted value, `done`=1, return to IDLE, `busy`=0.
- `start` while in SHIFT: ignored, with no queuing.
- `start` in the cycle where `done`=1 (state is IDLE): accepted normally.
- Arithmetic: ADD/SUB are modulo 2^32, with no flags other than `zero`.
- SLT: signed compare of a < b, result 32'd1/32'd0. SLTU: unsigned compare.
- AND/OR/XOR: bitwise.
- Undefined codes (0111, 1010, 11xx): single-cycle completion, `result`=0, `zero`=1.
- `b[31:5]` has no effect on shifts.
- `done` is deasserted on every edge where it is not explicitly set.

## Timing
- Reset (async, any time including mid-shift): state IDLE, count 0, `busy`=0, `done`=0, `result`=0, `zero`=1. Any in-flight shift is discarded.
- First edge after `rst` deasserts: `start` is sampled normally.
- Latency from start edge E0, for non-shift ops and shift-by-0: `done` and `result` are visible in the cycle after E0.
- Latency for shift by n>0: `busy` is high in the n cycles after E0. `done` and `result` are visible in the cycle after edge En. Maximum 31 edges for n=31.
- Throughput:
  - Single-cycle ops can be issued back-to-back, one per cycle.
  - A shift by n blocks new requests for n cycles.
- `result` and `zero` change only together with a `done` pulse, or on reset.

## Test plan
- ADD a=0xFFFFFFFF, b=0x1, start pulse:
  - Cycle after the start edge: `done`=1, `result`=0x0, `zero`=1, `busy`=0 throughout.
- SLT then SLTU back-to-back, a=0xFFFFFFFF, b=0x1:
  - First `done`: `result`=1.
  - Next cycle `done`: `result`=0.
  - Two consecutive `done` pulses.
- SRA a=0x80000000, b=0x4:
  - `busy`=1 for 4 cycles.
  - `done` after edge E4 with `result`=0xF8000000.
  - A `start` pulse with ADD at E2 is ignored, and `result` is unchanged until E4.
- SRL a=0x00000010, b=0xFFFFFF21 (shamt 1):
  - `done` after E1, `result`=0x00000008.
- SLL a=0x12345678, b=0x20 (shamt 0):
  - Single-cycle `done`, `result`=0x12345678, `busy` never high.
- SLL a=0x1, b=31, `rst` asserted asynchronously mid-shift, then released:
  - Immediately after assertion: `busy`=0, `done`=0, `result`=0, `zero`=1.
  - No `done` pulse follows.
  - A new XOR a=0xF0F0F0F0, b=0xFFFFFFFF gives `result`=0x0F0F0F0F after one edge.
